// File: rtl/score_tally_pkg.sv
// Shared encodings and constants for the score tally display feeder.
package score_tally_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_X    = 2'b01,
    RES_O    = 2'b10,
    RES_TIE  = 2'b11
  } result_e;

  localparam logic [7:0] TIE_TAG_DEFAULT = 8'hEE;
  localparam logic [7:0] BCD_MAX         = 8'h99;

  // Two-digit BCD +1.
  // The caller guards the 99 case, so the tens digit never passes 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/score_tally_bcd_counter_99.sv
// Two-digit BCD counter that saturates at 99 and has a synchronous clear.
import score_tally_pkg::*;

module bcd_counter_99 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] bcd
);

  // Clear wins over increment; the counter holds once it reaches 99.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bcd <= 8'h00;
    end else if (inc && (bcd != BCD_MAX)) begin
      bcd <= bcd_inc(bcd);
    end
  end

endmodule

// File: rtl/score_tally.sv
// Tic-tac-toe score keeper.
// Builds the 16-bit nibble word for the 4-digit display.
// The word alternates between an X:O score page and a tie page.
import score_tally_pkg::*;

module score_tally #(
  parameter int unsigned ROTATE_TICKS = 100_000_000,
  parameter int unsigned TIMER_W      = 27,
  parameter logic [7:0]  TIE_TAG      = TIE_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [1:0]  result,
  input  logic        clear_scores,
  input  logic        hold_page,
  output logic [15:0] big_bin,
  output logic        page,
  output logic        saturated
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROTATE_TICKS - 1);

  logic               prev_valid;
  logic               evt;
  logic               inc_x;
  logic               inc_o;
  logic               inc_t;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         x_cnt;
  logic [7:0]         o_cnt;
  logic [7:0]         t_cnt;

  // One event per rising edge of result_valid.
  // A result that stays high is never counted again.
  assign evt   = result_valid & ~prev_valid;
  assign inc_x = evt && (result == RES_X);
  assign inc_o = evt && (result == RES_O);
  assign inc_t = evt && (result == RES_TIE);

  // Remember the previous level of result_valid.
  // This register keeps updating during a clear, so a result still held
  // when the clear lifts is treated as already seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= result_valid;
    end
  end

  bcd_counter_99 u_x_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_scores),
    .inc (inc_x),
    .bcd (x_cnt)
  );

  bcd_counter_99 u_o_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_scores),
    .inc (inc_o),
    .bcd (o_cnt)
  );

  bcd_counter_99 u_t_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_scores),
    .inc (inc_t),
    .bcd (t_cnt)
  );

  // Page rotation timer.
  // The page flips every ROTATE_TICKS running cycles; hold_page freezes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      page  <= 1'b0;
    end else if (!hold_page) begin
      if (timer == TIMER_LAST) begin
        timer <= '0;
        page  <= ~page;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Register the display word and saturation flag from the updated state.
  // This puts big_bin one cycle behind the counters and the page bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      big_bin   <= 16'h0000;
      saturated <= 1'b0;
    end else begin
      big_bin   <= page ? {TIE_TAG, t_cnt} : {x_cnt, o_cnt};
      saturated <= (x_cnt == BCD_MAX) || (o_cnt == BCD_MAX) || (t_cnt == BCD_MAX);
    end
  end

endmodule

// File: tb/tb_score_tally.sv
// Bench for score_tally.
// A score model in plain integers is advanced once per clock and compared
// against the outputs.
module tb_score_tally;

  logic        clk = 1'b0;
  logic        rst;
  logic        result_valid;
  logic [1:0]  result;
  logic        clear_scores;
  logic        hold_page;
  logic [15:0] big_bin;
  logic        page;
  logic        saturated;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: plain win counts and the number of non-held cycles since reset
  int x_m, o_m, t_m, run_m;
  bit prev_m;

  always #5 clk = ~clk;

  score_tally #(
    .ROTATE_TICKS (4),
    .TIMER_W      (3),
    .TIE_TAG      (8'hEE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_valid (result_valid),
    .result       (result),
    .clear_scores (clear_scores),
    .hold_page    (hold_page),
    .big_bin      (big_bin),
    .page         (page),
    .saturated    (saturated)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic bit page_of(input int run);
    return bit'((run / 4) % 2);
  endfunction

  function automatic int sat_inc(input int n);
    return (n >= 99) ? 99 : n + 1;
  endfunction

  // Advance one clock.
  // The model produces the expected outputs for this edge, then all three
  // outputs are checked.
  task automatic step();
    logic [15:0] eb;
    logic        es;
    @(posedge clk);
    if (rst) begin
      x_m = 0; o_m = 0; t_m = 0; run_m = 0; prev_m = 0;
      eb = 16'h0000;
      es = 1'b0;
    end else begin
      eb = page_of(run_m) ? {8'hEE, to_bcd(t_m)} : {to_bcd(x_m), to_bcd(o_m)};
      es = (x_m == 99) || (o_m == 99) || (t_m == 99);
      if (clear_scores) begin
        x_m = 0; o_m = 0; t_m = 0;
      end else if (result_valid && !prev_m) begin
        case (result)
          2'b01:   x_m = sat_inc(x_m);
          2'b10:   o_m = sat_inc(o_m);
          2'b11:   t_m = sat_inc(t_m);
          default: ;
        endcase
      end
      prev_m = result_valid;
      if (!hold_page) run_m++;
    end
    #1;
    chk("big_bin", big_bin, eb);
    chk("page", {15'b0, page}, {15'b0, page_of(run_m)});
    chk("saturated", {15'b0, saturated}, {15'b0, es});
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [1:0] res, input int hi);
    result = res;
    result_valid = 1'b1;
    repeat (hi) step();
    result_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    result_valid = 1'b0;
    result = 2'b00;
    clear_scores = 1'b0;
    hold_page = 1'b1;
    x_m = 0; o_m = 0; t_m = 0; run_m = 0; prev_m = 0;

    // reset, then idle
    idle(2);
    rst = 1'b0;
    idle(10);
    chk("rst_big", big_bin, 16'h0000);
    chk("rst_page", {15'b0, page}, 16'h0000);
    chk("rst_sat", {15'b0, saturated}, 16'h0000);

    // X wins held long count once each
    repeat (4) pulse(2'b01, 20);
    idle(2);
    chk("x4", big_bin, 16'h0400);

    // O wins through the ones wrap and into saturation
    repeat (12) pulse(2'b10, 1);
    idle(2);
    chk("o12", big_bin, 16'h0412);
    repeat (100) pulse(2'b10, 1);
    idle(2);
    chk("o99", big_bin, 16'h0499);
    chk("o99_sat", {15'b0, saturated}, 16'h0001);

    // clear on the same edge as a tie event; the held tie must not count later
    result = 2'b11;
    result_valid = 1'b1;
    clear_scores = 1'b1;
    step();
    clear_scores = 1'b0;
    idle(3);
    result_valid = 1'b0;
    idle(2);
    chk("clr_big", big_bin, 16'h0000);
    chk("clr_sat", {15'b0, saturated}, 16'h0000);

    // ties, then let the pages rotate
    repeat (3) pulse(2'b11, 2);
    idle(1);
    hold_page = 1'b0;
    idle(4);
    chk("rot_page1", {15'b0, page}, 16'h0001);
    step();
    chk("rot_tie", big_bin, 16'hEE03);
    idle(3);
    chk("rot_page0", {15'b0, page}, 16'h0000);
    step();
    chk("rot_score", big_bin, 16'h0000);
    idle(3);
    hold_page = 1'b1;
    idle(10);
    chk("hold_page", {15'b0, page}, 16'h0001);
    chk("hold_big", big_bin, 16'hEE03);

    // reset while a result is held; it counts once after release
    hold_page = 1'b0;
    result = 2'b01;
    result_valid = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_page = 1'b1;
    idle(3);
    result_valid = 1'b0;
    idle(2);
    chk("rst_held", big_bin, 16'h0100);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      clear_scores = ($urandom_range(0, 79) == 0);
      hold_page    = ($urandom_range(0, 3) == 0);
      result       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) result_valid = ~result_valid;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_tally.md
Name: score_tally

Overview:
- Upstream feeder for the 4-digit seven-segment display path. It produces the 16-bit nibble word that the display stage multiplexes onto the digits.
- Keeps the tic-tac-toe match score: X wins, O wins and ties, each as a 2-digit BCD counter that saturates at 99.
- Alternates the display word between a score page (X:O) and a tie page on a fixed period.

Parameters:
- ROTATE_TICKS, 100_000_000: clk cycles per display page (1 s at 100 MHz); must be >= 2.
- TIMER_W, 27: width of the page timer; must satisfy 2**TIMER_W >= ROTATE_TICKS.
- TIE_TAG, 8'hEE: constant shown in the two leftmost digits of the tie page.

Ports:
- clk  input  1  system clock, the only clock.
- rst  input  1  reset, synchronous, active-high.
- result_valid  input  1  level from game logic; high while a finished game's result is held.
- result  input  2  2'b01 X win, 2'b10 O win, 2'b11 tie, 2'b00 none; sampled only on an event.
- clear_scores  input  1  synchronous clear of all three counters.
- hold_page  input  1  freezes the page timer and the current page while high.
- big_bin  output  16  display word, nibble [15:12] is the leftmost digit; registered.
- page  output  1  0 = score page, 1 = tie page; registered.
- saturated  output  1  high while any counter is at 99; registered.

Behaviour:
- Reset: all counters 00, prev_valid=0, timer=0, page=0, big_bin=16'h0000, saturated=0.
- Event detect: prev_valid <= result_valid every edge. event = result_valid & ~prev_valid, so there is one event per rising edge of result_valid. Holding result_valid high never re-counts.
- On an edge where event=1:
  - result 01 increments x_cnt.
  - result 10 increments o_cnt.
  - result 11 increments t_cnt.
  - result 00 changes nothing.
- BCD increment:
  - ones 0..9; at 9 the ones digit wraps to 0 and tens increments.
  - At 99 the counter holds at 99 (saturates, no wrap).
  - Digits are never >9.
- clear_scores=1: all counters go to 00 at that edge. Clear beats a simultaneous event; the event is lost. prev_valid still updates, so a result still held after the clear does not count.
- Page timer:
  - When hold_page=0, the timer increments each cycle.
  - At ROTATE_TICKS-1 the timer goes to 0 and page toggles.
  - When hold_page=1, timer and page hold.
  - clear_scores does not affect timer or page.
- big_bin, registered each edge from post-update state:
  - page 0: {x_tens, x_ones, o_tens, o_ones}.
  - page 1: {TIE_TAG, t_tens, t_ones}.
- Latency:
  - result_valid sampled high at edge N updates the counter at edge N. big_bin reflects it after edge N+1.
  - A page toggle at edge M changes big_bin content after edge M+1.
  - The page output updates at edge M (one cycle ahead of big_bin; accepted).
- saturated: registered OR of (cnt==99) over the three counters, same timing as big_bin.
- rst mid-game or mid-page: everything returns to reset values next edge. A result_valid still high after reset release counts once, because prev_valid was cleared.

Decomposition:
- Shared package/header: result encodings (RES_NONE, RES_X, RES_O, RES_TIE), TIE_TAG, and the BCD max constant (8'h99).
- One sub-module, bcd_counter_99:
  - inputs clk, rst, clr, inc; output [7:0] bcd; saturating.
  - Instantiated three times.
- Event detect, page timer and output mux stay in score_tally.

Test Plan (ROTATE_TICKS=4, hold_page=1 unless stated):
- Reset, then idle 10 cycles -> big_bin=16'h0000, page=0, saturated=0.
- result=01, result_valid held high 20 cycles, then low; repeat 3 more times -> big_bin=16'h0400 (X=04 counted once per assertion).
- 12 O-win pulses -> big_bin=16'h0412 (ones wrap 9->0, tens increments); 100 more O wins -> 16'h0499 and saturated=1.
- clear_scores asserted on the same edge as a tie event -> all counters 00, tie not counted, big_bin=16'h0000, saturated=0.
- 3 ties, hold_page=0 -> page toggles every 4 cycles; on page 1 big_bin=16'hEE03, on page 0 big_bin=16'h0000; setting hold_page=1 freezes page.
- result_valid high, assert rst for 1 cycle while still high, release -> the result counts once after reset (e.g. X win -> 16'h0100).
